puf_controller: RTL and testbench

PUF_CONTROLLER -- requirements
Module: puf_controller

---
 rtl/puf_pkg.sv | 19 +
 rtl/ro_edge_counter.sv | 46 ++++
 rtl/puf_controller.sv | 177 +++++++++++++++++
 tb/tb_puf_controller.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/puf_pkg.sv
// Shared types and default parameters for the ring-oscillator PUF controller.
package puf_pkg;

   localparam int NUM_RO_DEF    = 16;
   localparam int NUM_PAIRS_DEF = 8;
   localparam int CNT_W_DEF     = 16;
   localparam int WINDOW_DEF    = 1024;
   localparam int SETTLE_DEF    = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SETTLE,
      S_MEASURE,
      S_COMPARE,
      S_DONE
   } puf_state_t;

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of one asynchronous oscillator input.
// The input is double-flopped before edge detection.
// The count saturates at all-ones instead of wrapping.
module ro_edge_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ro,
   input  logic             clear,
   input  logic             count_en,
   output logic [CNT_W-1:0] count
);

   logic sync1;
   logic sync2;
   logic prev;
   logic rise;

   // Two-flop synchronizer plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         prev  <= 1'b0;
      end else begin
         sync1 <= ro;
         sync2 <= sync1;
         prev  <= sync2;
      end
   end

   assign rise = sync2 & ~prev;

   // Saturating edge counter; clear has priority over counting.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (count_en && rise && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/puf_controller.sv
// Ring-oscillator PUF controller.
// Each challenge pair enables two oscillators and counts their edges over a
// fixed window. The faster oscillator decides the response bit.
module puf_controller
   import puf_pkg::*;
#(
   parameter int NUM_RO    = NUM_RO_DEF,
   parameter int NUM_PAIRS = NUM_PAIRS_DEF,
   parameter int CNT_W     = CNT_W_DEF,
   parameter int WINDOW    = WINDOW_DEF,
   parameter int SETTLE    = SETTLE_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [NUM_PAIRS*8-1:0] challenge,
   input  logic [NUM_RO-1:0]      ro_in,
   output logic [NUM_RO-1:0]      ro_enable,
   output logic                   busy,
   output logic                   done,
   output logic [NUM_PAIRS-1:0]   response,
   output logic [NUM_PAIRS-1:0]   tie,
   output logic                   error
);

   localparam int PAIR_W  = (NUM_PAIRS > 1) ? $clog2(NUM_PAIRS) : 1;
   localparam int TMAX    = (WINDOW > SETTLE) ? WINDOW : SETTLE;
   localparam int TIMER_W = $clog2(TMAX + 1);

   puf_state_t               state;
   logic [NUM_PAIRS*8-1:0]   chal_q;
   logic [PAIR_W-1:0]        pair_idx;
   logic [TIMER_W-1:0]       timer;
   logic [7:0]               cur_byte;
   logic [7:0]               nxt_byte;
   logic                     ro_a;
   logic                     ro_b;
   logic                     cnt_clear;
   logic                     cnt_en;
   logic [CNT_W-1:0]         cnt_a;
   logic [CNT_W-1:0]         cnt_b;

   // Enable mask for one pair byte {idx_a, idx_b}; a repeated index yields one bit.
   function automatic logic [NUM_RO-1:0] pair_mask(input logic [7:0] pb);
      logic [NUM_RO-1:0] m;
      m = '0;
      for (int i = 0; i < NUM_RO; i++) begin
         if ((pb[7:4] == 4'(i)) || (pb[3:0] == 4'(i))) begin
            m[i] = 1'b1;
         end
      end
      return m;
   endfunction

   // Select the current/next pair bytes and route the chosen oscillators to the counters.
   always_comb begin
      cur_byte = '0;
      nxt_byte = '0;
      ro_a     = 1'b0;
      ro_b     = 1'b0;
      for (int p = 0; p < NUM_PAIRS; p++) begin
         if (pair_idx == PAIR_W'(p)) begin
            cur_byte = chal_q[p*8 +: 8];
         end
      end
      for (int p = 1; p < NUM_PAIRS; p++) begin
         if (pair_idx == PAIR_W'(p - 1)) begin
            nxt_byte = chal_q[p*8 +: 8];
         end
      end
      for (int i = 0; i < NUM_RO; i++) begin
         if (cur_byte[7:4] == 4'(i)) begin
            ro_a = ro_in[i];
         end
         if (cur_byte[3:0] == 4'(i)) begin
            ro_b = ro_in[i];
         end
      end
   end

   assign cnt_clear = (state == S_SETUP) || (state == S_SETTLE);
   assign cnt_en    = (state == S_MEASURE);

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
      .clk      (clk),
      .rst      (rst),
      .ro       (ro_a),
      .clear    (cnt_clear),
      .count_en (cnt_en),
      .count    (cnt_a)
   );

   ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
      .clk      (clk),
      .rst      (rst),
      .ro       (ro_b),
      .clear    (cnt_clear),
      .count_en (cnt_en),
      .count    (cnt_b)
   );

   // Challenge sequencing FSM with registered enable, status and result outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         chal_q    <= '0;
         pair_idx  <= '0;
         timer     <= '0;
         ro_enable <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         response  <= '0;
         tie       <= '0;
         error     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  chal_q    <= challenge;
                  response  <= '0;
                  tie       <= '0;
                  error     <= 1'b0;
                  pair_idx  <= '0;
                  ro_enable <= pair_mask(challenge[7:0]);
                  busy      <= 1'b1;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               timer <= '0;
               if (cur_byte[7:4] == cur_byte[3:0]) begin
                  error <= 1'b1;
               end
               state <= (SETTLE == 0) ? S_MEASURE : S_SETTLE;
            end
            S_SETTLE: begin
               if (timer == TIMER_W'(SETTLE - 1)) begin
                  timer <= '0;
                  state <= S_MEASURE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            S_MEASURE: begin
               if (timer == TIMER_W'(WINDOW - 1)) begin
                  timer     <= '0;
                  ro_enable <= '0;
                  state     <= S_COMPARE;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            S_COMPARE: begin
               response[pair_idx] <= (cur_byte[7:4] != cur_byte[3:0]) && (cnt_a > cnt_b);
               tie[pair_idx]      <= (cur_byte[7:4] != cur_byte[3:0]) && (cnt_a == cnt_b);
               if (pair_idx == PAIR_W'(NUM_PAIRS - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
               end else begin
                  pair_idx  <= pair_idx + PAIR_W'(1);
                  ro_enable <= pair_mask(nxt_byte);
                  state     <= S_SETUP;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_puf_controller.sv
// Self-checking bench for puf_controller: modelled oscillators, random challenges,
// a waveform-level reference model, and a second instance with a 4-bit counter.
module tb_puf_controller;

   localparam int N  = 8;
   localparam int W  = 40;
   localparam int ST = 4;
   localparam int L  = ST + W + 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [63:0] challenge = '0;
   logic [15:0] ro_in;

   logic [15:0] ro_enable, ro_enable_s;
   logic        busy, busy_s, done, done_s, error, error_s;
   logic [7:0]  response, response_s, tie, tie_s;

   int cyc = 0;
   int half [16];
   int phase [16];
   int check_count = 0;
   int pass_count = 0;

   puf_controller #(.NUM_RO(16), .NUM_PAIRS(N), .CNT_W(16), .WINDOW(W), .SETTLE(ST)) dut (
      .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
      .ro_enable(ro_enable), .busy(busy), .done(done), .response(response),
      .tie(tie), .error(error)
   );

   puf_controller #(.NUM_RO(16), .NUM_PAIRS(N), .CNT_W(4), .WINDOW(W), .SETTLE(ST)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .challenge(challenge), .ro_in(ro_in),
      .ro_enable(ro_enable_s), .busy(busy_s), .done(done_s), .response(response_s),
      .tie(tie_s), .error(error_s)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Oscillator i is a square wave with half-period half[i] clk cycles and offset phase[i].
   function automatic logic wave(input int i, input int t);
      return (((t + phase[i]) / half[i]) % 2) == 1;
   endfunction

   always @(negedge clk) begin
      for (int i = 0; i < 16; i++) ro_in[i] = wave(i, cyc);
   end

   // Rising edges seen by the controller during a window whose first counting edge is p0;
   // what reaches edge detection lags the pin by the synchronizer.
   function automatic int edges_in(input int i, input int p0);
      int n;
      n = 0;
      for (int j = 0; j < W; j++) begin
         if (!wave(i, p0 + j - 4) && wave(i, p0 + j - 3)) n++;
      end
      return n;
   endfunction

   function automatic logic [15:0] pair_enables(input logic [63:0] ch, input int k);
      logic [3:0]  a, b;
      logic [15:0] m;
      a = ch[8*k+4 +: 4];
      b = ch[8*k +: 4];
      m = '0;
      m[a] = 1'b1;
      m[b] = 1'b1;
      return m;
   endfunction

   // Expected results for a challenge whose start is sampled on clock edge s.
   function automatic void predict(input logic [63:0] ch, input int s, input int cw,
                                   output logic [7:0] r, output logic [7:0] t, output logic e);
      int na, nb, lim, p0;
      logic [3:0] a, b;
      lim = (1 << cw) - 1;
      r = '0;
      t = '0;
      e = 1'b0;
      for (int k = 0; k < N; k++) begin
         a = ch[8*k+4 +: 4];
         b = ch[8*k +: 4];
         if (a == b) begin
            e = 1'b1;
         end else begin
            p0 = s + k*L + ST + 2;
            na = edges_in(int'(a), p0);
            nb = edges_in(int'(b), p0);
            if (na > lim) na = lim;
            if (nb > lim) nb = lim;
            r[k] = (na > nb);
            t[k] = (na == nb);
         end
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      check_count++;
      if (got === want) pass_count++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
   endtask

   task automatic randomOsc();
      for (int i = 0; i < 16; i++) begin
         half[i]  = $urandom_range(1, 6);
         phase[i] = $urandom_range(0, 11);
      end
   endtask

   function automatic logic [63:0] randChal();
      return {$urandom, $urandom};
   endfunction

   // Run one challenge to completion, monitoring enables and checking results.
   task automatic applyStimulus(input logic [63:0] ch, input bit poke_start);
      logic [7:0] er16, et16, er4, et4;
      logic       ee16, ee4;
      int s, start_cyc, r, k, ph, waited;
      @(negedge clk);
      challenge = ch;
      start     = 1'b1;
      start_cyc = cyc;
      s         = cyc + 1;
      predict(ch, s, 16, er16, et16, ee16);
      predict(ch, s, 4, er4, et4, ee4);
      @(negedge clk);
      start = 1'b0;
      checkOutput("busy_after_start", busy, 1);
      checkOutput("response_cleared", response, 0);
      checkOutput("tie_cleared", tie, 0);
      checkOutput("error_cleared", error, 0);
      challenge = randChal();
      for (waited = 0; waited < N*L + 20 && !done; waited++) begin
         r  = cyc - s;
         k  = r / L;
         ph = r % L;
         if (k < N) begin
            if (ph == 0 || ph == ST + 2 + W/2)
               checkOutput("ro_enable_pair", ro_enable, pair_enables(ch, k));
            if (ph == L - 1)
               checkOutput("ro_enable_compare", ro_enable, 0);
         end
         start = poke_start && (r == L + 5);
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput("done_seen", done, 1);
      checkOutput("latency", cyc - start_cyc, 1 + N*L);
      checkOutput("busy_at_done", busy, 0);
      checkOutput("ro_enable_at_done", ro_enable, 0);
      checkOutput("response", response, er16);
      checkOutput("tie", tie, et16);
      checkOutput("error", error, ee16);
      checkOutput("sat_done", done_s, 1);
      checkOutput("sat_response", response_s, er4);
      checkOutput("sat_tie", tie_s, et4);
      checkOutput("sat_error", error_s, ee4);
      @(negedge clk);
      checkOutput("done_one_cycle", done, 0);
      repeat (3) @(negedge clk);
      checkOutput("response_hold", response, er16);
      checkOutput("tie_hold", tie, et16);
      checkOutput("ro_enable_idle", ro_enable, 0);
   endtask

   initial begin
      logic [63:0] ch;
      int s, done_count;
      randomOsc();
      for (int i = 0; i < 16; i++) ro_in[i] = wave(i, 0);

      $display("[TB] reset state");
      repeat (3) @(negedge clk);
      checkOutput("reset_ro_enable", ro_enable, 0);
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_response", response, 0);
      checkOutput("reset_error", error, 0);
      rst = 1'b1;
      repeat (4) @(negedge clk);

      $display("[TB] pair (3,7)");
      randomOsc();
      half[3] = 3; phase[3] = 0; half[7] = 5; phase[7] = 0;
      ch = randChal(); ch[7:0] = 8'h37;
      applyStimulus(ch, 1'b0);
      checkOutput("pair37_response0", response[0], 1);
      checkOutput("pair37_tie0", tie[0], 0);

      $display("[TB] pair (7,3)");
      ch = randChal(); ch[7:0] = 8'h73;
      applyStimulus(ch, 1'b0);
      checkOutput("pair73_response0", response[0], 0);
      checkOutput("pair73_tie0", tie[0], 0);

      $display("[TB] equal oscillators (1,2)");
      half[1] = 4; phase[1] = 2; half[2] = 4; phase[2] = 2;
      ch = randChal(); ch[7:0] = 8'h12;
      applyStimulus(ch, 1'b0);
      checkOutput("pair12_tie0", tie[0], 1);
      checkOutput("pair12_response0", response[0], 0);

      $display("[TB] repeated index (5,5)");
      ch = randChal(); ch[7:0] = 8'h55;
      applyStimulus(ch, 1'b0);
      checkOutput("pair55_error", error, 1);
      checkOutput("pair55_response0", response[0], 0);

      $display("[TB] saturation (0,8)");
      half[0] = 1; phase[0] = 0; half[8] = 2; phase[8] = 1;
      ch = randChal(); ch[7:0] = 8'h08;
      applyStimulus(ch, 1'b0);
      checkOutput("sat_pair08_response0", response_s[0], 1);
      checkOutput("full_pair08_response0", response[0], 1);

      $display("[TB] random challenges");
      for (int it = 0; it < 5; it++) begin
         randomOsc();
         applyStimulus(randChal(), it == 2);
      end

      $display("[TB] reset during measurement of pair 3");
      @(negedge clk);
      challenge = randChal();
      start = 1'b1;
      s = cyc + 1;
      @(negedge clk);
      start = 1'b0;
      while (cyc < s + 3*L + ST + 12) @(negedge clk);
      checkOutput("busy_before_abort", busy, 1);
      #1 rst = 1'b0;
      #1;
      checkOutput("abort_ro_enable", ro_enable, 0);
      checkOutput("abort_busy", busy, 0);
      checkOutput("abort_response", response, 0);
      checkOutput("abort_tie", tie, 0);
      checkOutput("abort_error", error, 0);
      checkOutput("abort_done", done, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      done_count = 0;
      for (int i = 0; i < N*L + 10; i++) begin
         @(negedge clk);
         if (done) done_count++;
      end
      checkOutput("no_done_after_abort", done_count, 0);
      checkOutput("idle_after_abort", busy, 0);

      $display("[TB] fresh challenge after abort");
      randomOsc();
      applyStimulus(randChal(), 1'b0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
